// File: rtl/mem_pkg.sv
// Shared memory-system constants and the arbiter state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

  localparam int ADDR_W     = 8;    // 256-byte unified memory
  localparam int DATA_W     = 8;    // byte-wide data port
  localparam int BOOT_LEN   = 128;  // instruction region is 0..BOOT_LEN-1
  localparam int DATA_BASE  = 128;  // memory adds this to D_addr
  localparam int STARVE_LIM = 4;    // refused DMA cycles before DMA is forced

  // Width of the DMA starvation counter (must hold 0..STARVE_LIM).
  localparam int STARVE_W   = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // D_addr value that lands on physical address 'phys' once the memory
  // has added DATA_BASE (modulo the address space).
  function automatic logic [ADDR_W-1:0] phys_to_daddr(input logic [ADDR_W-1:0] phys);
    logic [ADDR_W-1:0] offset;
    offset = ADDR_W'((2**ADDR_W - DATA_BASE) % (2**ADDR_W));
    return phys + offset;
  endfunction

endpackage

// File: rtl/mem_boot_loader.sv
// Boot image loader: writes streamed bytes to physical 0.. and counts them.
// Latency: write issued combinationally in the handshake cycle; count updates next edge.
// Backpressure: ld_ready follows 'en'; no bytes are accepted outside BOOT.
module mem_boot_loader
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] boot_cnt,
  output logic              done
);

  logic hs;

  // Handshake, write port and exit detection; the last slot of the
  // instruction region ends boot even without ld_last so nothing spills
  // into the data region.
  always_comb begin
    ld_ready = en;
    hs       = ld_valid & en;
    wr_en    = hs;
    wr_addr  = phys_to_daddr(boot_cnt);
    wr_data  = ld_data;
    done     = hs & (ld_last | (boot_cnt == ADDR_W'(BOOT_LEN - 1)));
  end

  // Byte counter; it freezes once BOOT is left because 'en' drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt <= '0;
    end else if (hs) begin
      boot_cnt <= boot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the memory data/write port: boot loader first, then CPU vs DMA.
// Latency: grants and port mux are combinational; FSM and starve counter register.
// Backpressure: CPU stalled during boot or when DMA is forced; DMA waits via dma_gnt.
module mem_access_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_d_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_wen,
  output logic              dma_gnt,
  output logic              cpu_stall,
  output logic              core_run,
  output logic [ADDR_W-1:0] boot_cnt,
  output logic [ADDR_W-1:0] mem_d_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen
);

  state_t              state;
  state_t              state_nxt;
  logic [STARVE_W-1:0] starve;
  logic                cpu_acc;
  logic                force_dma;

  logic                bl_wr_en;
  logic [ADDR_W-1:0]   bl_wr_addr;
  logic [DATA_W-1:0]   bl_wr_data;
  logic                bl_done;

  mem_boot_loader u_boot (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_BOOT),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .wr_en    (bl_wr_en),
    .wr_addr  (bl_wr_addr),
    .wr_data  (bl_wr_data),
    .boot_cnt (boot_cnt),
    .done     (bl_done)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the port mux: boot owns the port in BOOT, CPU/DMA in RUN.
  always_comb begin
    state_nxt  = state;
    core_run   = 1'b0;
    cpu_stall  = 1'b1;
    dma_gnt    = 1'b0;
    mem_d_addr = '0;
    mem_wdata  = '0;
    mem_wen    = 1'b0;
    cpu_acc    = cpu_ren | cpu_wen;
    force_dma  = dma_req & (starve == STARVE_W'(STARVE_LIM));

    case (state)
      ST_IDLE: begin
        state_nxt = ST_BOOT;
      end
      ST_BOOT: begin
        mem_d_addr = bl_wr_addr;
        mem_wdata  = bl_wr_data;
        mem_wen    = bl_wr_en;
        if (bl_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (cpu_acc && !force_dma) begin
          // A simultaneous read and write request is treated as a write.
          cpu_stall  = 1'b0;
          mem_d_addr = cpu_d_addr;
          mem_wdata  = cpu_wdata;
          mem_wen    = cpu_wen;
        end else if (dma_req) begin
          dma_gnt    = 1'b1;
          cpu_stall  = cpu_acc;
          mem_d_addr = dma_addr;
          mem_wdata  = dma_wdata;
          mem_wen    = dma_wen;
        end else begin
          cpu_stall  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // DMA starvation counter: counts consecutive refused RUN cycles, saturating
  // at the limit so the following cycle forces DMA through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (state == ST_RUN && dma_req && !dma_gnt) begin
      if (starve != STARVE_W'(STARVE_LIM)) begin
        starve <= starve + 1'b1;
      end
    end else begin
      starve <= '0;
    end
  end

endmodule
